// File: rtl/lr35902_joypad_pkg.sv
// lr35902_joypad_pkg
//   Shared defaults and readback-layout constants for the joypad block.
//   JP_N_IN / JP_N_SEL    : default return-line / select-line counts
//   JP_DB_CYCLES          : default debounce length in cycles
//   JP_EDGE_MODE          : default irq edge selection (0 = falling only)
//   JP_DOUT_W / JP_FILL   : readback width and value of the unused upper bits
package lr35902_joypad_pkg;
  localparam int         JP_N_IN      = 4;
  localparam int         JP_N_SEL     = 2;
  localparam int         JP_DB_CYCLES = 15;
  localparam int         JP_EDGE_MODE = 0;
  localparam int         JP_DOUT_W    = 8;
  localparam logic [7:0] JP_FILL      = 8'hFF;

  // Readback word: unused bits read as ones, select lines above the returns.
  function automatic logic [JP_DOUT_W-1:0] jp_pack(input logic [JP_DOUT_W-1:0] sel,
                                                  input logic [JP_DOUT_W-1:0] keys,
                                                  input int n_in, input int n_sel);
    logic [JP_DOUT_W-1:0] w;
    w = JP_FILL;
    for (int b = 0; b < JP_DOUT_W; b++) begin
      if (b < n_in)                 w[b] = keys[b];
      else if (b < n_in + n_sel)    w[b] = sel[b - n_in];
    end
    return w;
  endfunction
endpackage

// File: rtl/lr35902_debounce.sv
// lr35902_debounce
//   One return line: 2-flop synchronizer, mismatch counter, stable level.
//   clk, reset : clock, synchronous active-high reset
//   pin        : raw asynchronous input
//   stable     : debounced level (resets high = released)
module lr35902_debounce #(
  parameter int DB_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '1;
      cnt    <= '0;
      stable <= 1'b1;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        // DB_CYCLES-th consecutive mismatch: accept the new level
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/lr35902_joypad.sv
// lr35902_joypad
//   Key-matrix joypad register: select-line latch, debounced return lines,
//   edge interrupt and registered readback.
//   clk, reset : clock, synchronous active-high reset
//   din, write : CPU write data / strobe (commit on strobe falling edge)
//   dout       : {ones, pin_sel, stable} registered readback
//   irq        : one-cycle pulse on debounced edge(s)
//   pin_in     : raw active-low return lines
//   pin_sel    : registered select-line drive
module lr35902_joypad
  import lr35902_joypad_pkg::*;
#(
  parameter int N_IN      = JP_N_IN,
  parameter int N_SEL     = JP_N_SEL,
  parameter int DB_CYCLES = JP_DB_CYCLES,
  parameter int EDGE_MODE = JP_EDGE_MODE
) (
  input  logic             clk,
  input  logic             reset,
  output logic [7:0]       dout,
  input  logic [7:0]       din,
  input  logic             write,
  output logic             irq,
  input  logic [N_IN-1:0]  pin_in,
  output logic [N_SEL-1:0] pin_sel
);
  generate
    if (DB_CYCLES < 1 || N_IN + N_SEL > JP_DOUT_W) begin : g_bad_param
      $error("lr35902_joypad: need DB_CYCLES >= 1 and N_IN+N_SEL <= 8");
    end
  endgenerate

  logic [N_IN-1:0] stable, stable_d, evt;
  logic [7:0]      rd, rd_rst;
  logic            pwrite, commit;

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    lr35902_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb (
      .clk    (clk),
      .reset  (reset),
      .pin    (pin_in[i]),
      .stable (stable[i])
    );
  end

  assign commit = pwrite & ~write;

  // stable_d is stable one cycle late, so the edge is seen the cycle after
  // stable moves and irq lands one cycle after that.
  always_comb begin
    evt = stable_d & ~stable;
    if (EDGE_MODE != 0) evt = evt | (~stable_d & stable);
  end

  always_comb begin
    rd     = jp_pack(8'(pin_sel), 8'(stable), N_IN, N_SEL);
    rd_rst = jp_pack(8'h00, 8'hFF, N_IN, N_SEL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwrite   <= 1'b0;
      pin_sel  <= '0;
      stable_d <= '1;
      irq      <= 1'b0;
      dout     <= rd_rst;
    end else begin
      pwrite   <= write;
      if (commit) pin_sel <= din[N_IN+N_SEL-1:N_IN];
      stable_d <= stable;
      irq      <= |evt;
      dout     <= rd;
    end
  end
endmodule

// File: tb/tb_lr35902_joypad.sv
// tb_lr35902_joypad
//   Directed bench: two DUTs (EDGE_MODE 0 and 1) share all inputs.
module tb_lr35902_joypad;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       write;
  logic [3:0] pin_in;
  logic [7:0] dout0, dout1;
  logic       irq0, irq1;
  logic [1:0] sel0, sel1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lr35902_joypad #(.EDGE_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .dout(dout0), .din(din), .write(write),
    .irq(irq0), .pin_in(pin_in), .pin_sel(sel0)
  );
  lr35902_joypad #(.EDGE_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .dout(dout1), .din(din), .write(write),
    .irq(irq1), .pin_in(pin_in), .pin_sel(sel1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    write  = 1'b0;
    din    = 8'h00;
    pin_in = 4'hF;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_dout0", dout0, 8'hCF);
    chk("rst_dout1", dout1, 8'hCF);
    chk("rst_irq0", {7'b0, irq0}, 8'h00);
    chk("rst_sel0", {6'b0, sel0}, 8'h00);

    // single key press, full debounce latency
    pin_in[2] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("press2_irq0_e%0d", k), {7'b0, irq0}, (k == 17) ? 8'h01 : 8'h00);
      chk($sformatf("press2_dout_e%0d", k), dout0, (k >= 17) ? 8'hCB : 8'hCF);
    end

    // glitch of DB_CYCLES-1 cycles is rejected
    do_reset();
    pin_in[0] = 1'b0;
    for (int k = 0; k < 14; k++) step();
    pin_in[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("glitch_irq0_%0d", k), {7'b0, irq0}, 8'h00);
      chk($sformatf("glitch_irq1_%0d", k), {7'b0, irq1}, 8'h00);
      chk($sformatf("glitch_dout_%0d", k), dout0, 8'hCF);
      step();
    end

    // select write: commit on strobe fall, din ignored while strobe high
    do_reset();
    write = 1'b1;
    din = 8'h30; step(); chk("wr_hold1_sel", {6'b0, sel0}, 8'h00);
    din = 8'h10; step(); chk("wr_hold2_sel", {6'b0, sel0}, 8'h00);
    din = 8'h20; step(); chk("wr_hold3_sel", {6'b0, sel0}, 8'h00);
    write = 1'b0;
    step();
    chk("wr_commit_sel", {6'b0, sel0}, 8'h02);
    chk("wr_commit_dout", dout0, 8'hCF);
    din = 8'h30;
    step();
    chk("wr_dout_next", dout0, 8'hEF);
    chk("wr_nocommit_sel", {6'b0, sel0}, 8'h02);

    // reset beats a simultaneous commit
    write = 1'b1; step();
    write = 1'b0; reset = 1'b1; step();
    chk("rst_vs_commit_sel", {6'b0, sel0}, 8'h00);
    reset = 1'b0;

    // two keys in the same cycle: one pulse; release edge only in EDGE_MODE=1
    do_reset();
    pin_in = 4'b0101;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("dual_irq0_e%0d", k), {7'b0, irq0}, (k == 17) ? 8'h01 : 8'h00);
      chk($sformatf("dual_irq1_e%0d", k), {7'b0, irq1}, (k == 17) ? 8'h01 : 8'h00);
      chk($sformatf("dual_dout_e%0d", k), dout1, (k >= 17) ? 8'hC5 : 8'hCF);
    end
    pin_in = 4'hF;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("rel_irq0_e%0d", k), {7'b0, irq0}, 8'h00);
      chk($sformatf("rel_irq1_e%0d", k), {7'b1 & 7'b0, irq1}, (k == 17) ? 8'h01 : 8'h00);
      chk($sformatf("rel_dout_e%0d", k), dout0, (k >= 17) ? 8'hCF : 8'hC5);
    end

    // reset mid-debounce with key held low, then full latency from release
    do_reset();
    pin_in[0] = 1'b0;
    for (int k = 0; k < 12; k++) step();
    chk("mid_cnt", 8'(dut0.g_lane[0].u_deb.cnt), 8'd10);
    reset = 1'b1;
    step();
    chk("mid_rst_cnt", 8'(dut0.g_lane[0].u_deb.cnt), 8'd0);
    chk("mid_rst_stable", {7'b0, dut0.g_lane[0].u_deb.stable}, 8'h01);
    chk("mid_rst_irq", {7'b0, irq0}, 8'h00);
    chk("mid_rst_dout", dout0, 8'hCF);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("held_irq0_e%0d", k), {7'b0, irq0}, (k == 17) ? 8'h01 : 8'h00);
      chk($sformatf("held_dout_e%0d", k), dout0, (k >= 17) ? 8'hCE : 8'hCF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
